prio_req_encoder: RTL
=====================

Name: prio_req_encoder

Overview:
- Parametrised, registered successor to the team's one-hot 8→3 encoder.
- Captures request pulses from N sources into a pending register and encodes them by priority one at a time.
- Presents each encoded index on a valid/ready output with backpressure.
- Sits between interrupt/event sources and a single consumer, such as an event sequencer or IRQ dispatcher.

Parameters:
- N, 8, number of request lines (2..64).
- HI_FIRST, 1, priority mode: 1 means the highest index wins, 0 means the lowest index wins.
- W, $clog2(N), index width; localparam derived from N, not user-set.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  N  request pulses; bit k high for one cycle raises request k.
- out_valid_o  out  1  out_idx_o holds an unconsumed index.
- out_ready_i  in  1  consumer accepts the index; transfer occurs when valid and ready are both high.
- out_idx_o  out  W  encoded index of the served request.
- pend_o  out  N  requests captured but not yet loaded into the output stage.
- pend_cnt_o  out  W+1  population count of pend_o.
- drop_o  out  1  one-cycle pulse: a request arrived on a line that was already pending.

Behaviour:
- Reset (async assert, sync release): P=0, out_valid_o=0, out_idx_o=0, drop_o=0, pend_cnt_o=0.
  - Reset asserted mid-operation discards all pending and in-flight indices immediately.
- State: pending register P[N-1:0] and output register {out_valid_o, out_idx_o}.
  - pend_o = P.
  - pend_cnt_o is the registered popcount of P, updated in the same cycle as P.
- Select: sel = priority encode of P (registered value only).
  - HI_FIRST=1: sel is the highest set bit. HI_FIRST=0: sel is the lowest set bit.
  - any = |P.
- load = any && (!out_valid_o || out_ready_i).
- On load: out_idx_o <= sel, out_valid_o <= 1, and bit sel is cleared from P in the same edge.
- Drain: if !load and out_valid_o && out_ready_i, then out_valid_o <= 0 and out_idx_o holds its value.
- P update: P_next = (P & ~clr) | req_i, where clr = onehot(sel) when load, else 0.
  - Set wins over clear: a request on the bit being loaded this cycle re-arms that bit.
- Drop: drop_o <= |(req_i & P & ~clr), registered, so the pulse appears one cycle after the colliding req_i.
  - The duplicate is absorbed; no second entry is created.
  - A request on the index currently held in the output register is not a duplicate; it is accepted into P.
- Latency: req_i at edge t sets P at t+1; out_valid_o rises after edge t+2 if the output stage is free.
  - Requests arriving in cycle t are invisible to selection until t+1.
- Throughput: with out_ready_i held high, one index per cycle, with no bubble between back-to-back loads.
- Stability: while out_valid_o && !out_ready_i, out_idx_o and out_valid_o must not change; new requests only accumulate in P.
- Empty: P=0 and the output consumed gives out_valid_o=0; no spurious loads.
- Full: all N bits pending is legal; requests beyond that collapse into drops.
- Width rules: pend_cnt_o ranges 0..N inclusive, hence W+1 bits. Index values are always < N.

Decomposition:
- Package prio_enc_pkg holds:
  - localparams HI_FIRST_MODE=1 and LO_FIRST_MODE=0.
  - function clog2_safe(n), returning 1 for n<=2.
  - function popcount(vec).
- Sub-module prio_enc_comb (N, HI_FIRST): purely combinational vector → {found, idx[W-1:0]}.
  - Reused elsewhere to replace the fixed 8→3 encoder.
- The top level contains only the P register, output stage, drop logic and counters.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-stream with P=8'hFF and out_valid_o=1 → outputs drop to out_valid_o=0, pend_o=0, pend_cnt_o=0, drop_o=0 without waiting for a clock edge.
- Single request: N=8, HI_FIRST=1, out_ready_i=1, req_i=8'h10 for one cycle at edge t → out_valid_o=1 with out_idx_o=4 for exactly one cycle starting at t+2; pend_o returns to 0.
- Burst ordering: req_i=8'hA5 pulse, out_ready_i=1 → out_idx_o sequence 7,5,2,0 on consecutive cycles. Repeat with HI_FIRST=0 → 0,2,5,7. pend_cnt_o steps 4,3,2,1,0.
- Backpressure: out_ready_i=0, req_i=8'h03 → out_idx_o=1 held stable with pend_o=8'h01 and pend_cnt_o=1 for 10 cycles. Raise out_ready_i → indices 1 then 0, then out_valid_o=0.
- Duplicate and re-arm:
  - With out_ready_i=0, req_i=8'h0C at t, then req_i=8'h04 at t+3 → out_idx_o=3, pend_o stays 8'h04, drop_o pulses at t+4.
  - Then req_i=8'h08 while index 3 is still held → accepted, pend_o=8'h0C, no drop.
- Set-wins collision: out_ready_i=1, P=8'h01, req_i=8'h01 asserted in the cycle bit 0 is loaded → P stays 8'h01, no drop_o, and index 0 is emitted twice.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority request encoder family:
// priority-mode constants plus width and population-count helpers.
package prio_enc_pkg;

    localparam int HI_FIRST_MODE = 1;
    localparam int LO_FIRST_MODE = 0;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int clog2_safe(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 7; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of set bits in a vector of up to 64 bits (callers zero-extend).
    function automatic logic [6:0] popcount(input logic [63:0] vec);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: reports whether any bit of vec is set and
// the index of the winning bit (highest or lowest, selected by HI_FIRST).
module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter int N        = 8,
    parameter int HI_FIRST = HI_FIRST_MODE,
    localparam int W       = clog2_safe(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan toward the preferred end so the last match seen is the winner.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        found = 1'b0;
        idx   = '0;
        if (HI_FIRST == LO_FIRST_MODE) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (vec[k]) begin
                    found = 1'b1;
                    idx   = W'(k);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (vec[k]) begin
                    found = 1'b1;
                    idx   = W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/prio_req_encoder.sv
// Registered priority request encoder: request pulses accumulate in a pending
// register and are handed out one index at a time on a valid/ready port.
module prio_req_encoder
    import prio_enc_pkg::*;
#(
    parameter int N        = 8,
    parameter int HI_FIRST = HI_FIRST_MODE,
    localparam int W       = clog2_safe(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_idx_o,
    output logic [N-1:0] pend_o,
    output logic [W:0]   pend_cnt_o,
    output logic         drop_o
);

    logic [N-1:0] pend_q;
    logic [W:0]   pend_cnt_q;
    logic         any;
    logic [W-1:0] sel;
    logic         load;
    logic [N-1:0] clr;
    logic [N-1:0] pend_next;
    logic         dup;

    // Selection looks only at the registered pending set, so a request is
    // never served in the cycle it arrives.
    prio_enc_comb #(
        .N        (N),
        .HI_FIRST (HI_FIRST)
    ) u_enc (
        .vec   (pend_q),
        .found (any),
        .idx   (sel)
    );

    // Load when something is pending and the output stage is empty or draining;
    // a new request on the loaded bit re-arms it (set wins over clear).
    always_comb begin
        load      = any && (!out_valid_o || out_ready_i);
        clr       = load ? (N'(1) << sel) : '0;
        pend_next = (pend_q & ~clr) | req_i;
        dup       = |(req_i & pend_q & ~clr);
    end

    // Pending set, its population count, drop pulse and the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            pend_cnt_q  <= '0;
            drop_o      <= 1'b0;
            out_valid_o <= 1'b0;
            out_idx_o   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            pend_q     <= pend_next;
            pend_cnt_q <= (W + 1)'(popcount(64'(pend_next)));
            drop_o     <= dup;
            if (load) begin
                out_valid_o <= 1'b1;
                out_idx_o   <= sel;
            end else if (out_valid_o && out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

    assign pend_o     = pend_q;
    assign pend_cnt_o = pend_cnt_q;

endmodule
